// File: rtl/pipe_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctl
//  Purpose  : Pipeline hazard controller for the 5-stage MIPS core. Drives the
//             stall/zero controls of IF/ID, ID/EX, EX/MEM, MEM/WB and the PC
//             hold, and keeps saturating stall/branch-flush counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_ctl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rt,
   input  logic             ex_branch_taken,
   input  logic             imem_ready,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             stall_pc,
   output logic             stall_ifid,
   output logic             zero_ifid,
   output logic             stall_idex,
   output logic             zero_idex,
   output logic             stall_exmem,
   output logic             zero_exmem,
   output logic             stall_memwb,
   output logic             zero_memwb,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int               FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0]  FC_INIT = FC_W'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      S_FLUSH = 2'd0,
      S_RUN   = 2'd1,
      S_DWAIT = 2'd2
   } state_t;

   state_t             r_state;
   logic [FC_W-1:0]    r_fc;
   logic [CNT_W-1:0]   r_stall_cnt;
   logic [CNT_W-1:0]   r_flush_cnt;

   logic w_flushing;
   logic w_dstall;
   logic w_lu;
   logic w_br;
   logic w_iw;
   logic w_br_fire;

   // Hazard terms; DWAIT shares the RUN decode, only FLUSH masks everything.
   always_comb begin
      w_flushing = (r_state == S_FLUSH);
      w_dstall   = mem_req & ~mem_ready;
      w_lu       = ex_memread & (ex_rt != 5'd0) &
                   ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
      w_br       = ex_branch_taken;
      w_iw       = ~imem_ready;
      // A data wait freezes EX, so a taken branch only squashes once it clears.
      w_br_fire  = ~w_flushing & ~w_dstall & w_br;
   end

   // Prioritised control decode: flush > data wait > branch > load-use > fetch wait.
   always_comb begin
      stall_pc    = 1'b0;
      stall_ifid  = 1'b0;
      zero_ifid   = 1'b0;
      stall_idex  = 1'b0;
      zero_idex   = 1'b0;
      stall_exmem = 1'b0;
      zero_exmem  = 1'b0;
      stall_memwb = 1'b0;
      zero_memwb  = 1'b0;
      if (w_flushing) begin
         stall_pc   = 1'b1;
         zero_ifid  = 1'b1;
         zero_idex  = 1'b1;
         zero_exmem = 1'b1;
         zero_memwb = 1'b1;
      end else if (w_dstall) begin
         stall_pc    = 1'b1;
         stall_ifid  = 1'b1;
         stall_idex  = 1'b1;
         stall_exmem = 1'b1;
         zero_memwb  = 1'b1;
      end else if (w_br) begin
         // PC keeps advancing so it can load the branch target even during a fetch wait.
         zero_ifid = 1'b1;
         zero_idex = 1'b1;
      end else if (w_lu) begin
         stall_pc   = 1'b1;
         stall_ifid = 1'b1;
         zero_idex  = 1'b1;
      end else if (w_iw) begin
         stall_pc  = 1'b1;
         zero_ifid = 1'b1;
      end
   end

   // State machine, flush down-counter and saturating performance counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_FLUSH;
         r_fc        <= FC_INIT;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         case (r_state)
            S_FLUSH: begin
               if (r_fc == '0) begin
                  r_state <= S_RUN;
               end else begin
                  r_fc <= r_fc - FC_W'(1);
               end
            end
            S_RUN: begin
               if (w_dstall) begin
                  r_state <= S_DWAIT;
               end
            end
            S_DWAIT: begin
               if (!w_dstall) begin
                  r_state <= S_RUN;
               end
            end
            default: begin
               r_state <= S_FLUSH;
               r_fc    <= FC_INIT;
            end
         endcase

         if (!w_flushing && stall_pc && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (w_br_fire && !(&r_flush_cnt)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire
